ahb_lsu_master: RTL and testbench
=================================

Name: ahb_lsu_master

Overview:
- Load/store bus master directly downstream of the register-file array.
- Consumes the array's memory address and store data, and runs one AHB-Lite single transfer per request, inserting wait states as the slave demands.
- Returns size-extracted, sign- or zero-extended load data to the array's memory-data input.
- Produces the transfer_on / hready_in pair that gates register write-back.

Parameters:
ADDR_W, 32, width of the address and HADDR
DATA_W, 32, width of the data path (fixed 32; byte-lane logic assumes 4 lanes)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  load/store request from control
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  zero-extend loads (LBU/LHU)
addr_in  input  ADDR_W  effective address (array address output)
wdata_in  input  DATA_W  store data (array store-data output)
req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready
transfer_on  output  1  high while a bus transfer is outstanding
rf_hready  output  1  one-cycle pulse when load_data is valid for register write
load_data  output  DATA_W  extracted and extended load result
misalign_err  output  1  one-cycle pulse for a misaligned or illegal-size request
bus_err  output  1  one-cycle pulse when the slave returns ERROR
haddr  output  ADDR_W  AHB address
htrans  output  2  00 IDLE, 10 NONSEQ only
hwrite  output  1  AHB write
hsize  output  3  {1'b0, req_size}
hwdata  output  DATA_W  AHB write data, lane-replicated
hrdata  input  DATA_W  AHB read data
hready  input  1  AHB ready
hresp  input  1  AHB response (1 = ERROR)

Behaviour:
- Reset (synchronous, rst high at a clk edge) values:
  - State IDLE; htrans=00; haddr, hwdata, hsize, hwrite, load_data all 0.
  - transfer_on=0, rf_hready=0, misalign_err=0, bus_err=0.
  - req_ready=1 once rst is released.
- Reset mid-transfer: the block returns to IDLE in the next cycle, the transfer is abandoned, and no rf_hready or bus_err pulse is issued.
- FSM states: IDLE, ADDR, DATA, ERR2.
- IDLE:
  - req_ready=1; htrans=00.
  - On accept, check alignment. Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - If misaligned: pulse misalign_err next cycle and stay IDLE; no bus activity.
  - Otherwise latch addr, size, write, unsigned and lane-replicated wdata, then go to ADDR.
- ADDR:
  - htrans=10; haddr, hwrite and hsize are driven from the latched values.
  - Stay in ADDR while hready=0. On hready=1, go to DATA.
- DATA:
  - htrans=00; hwdata holds the latched store data throughout.
  - hready=0 and hresp=0: wait.
  - hready=0 and hresp=1: go to ERR2.
  - hready=1 and hresp=0:
    - For a load, register the extracted data into load_data and pulse rf_hready next cycle.
    - For a store, no pulse.
    - Then go to IDLE.
- ERR2: wait for hready=1, then pulse bus_err next cycle and go to IDLE. load_data is not updated.
- transfer_on = (state != IDLE).
- Latency: with zero wait states, accept at cycle 0, address phase at cycle 1, data phase at cycle 2, and rf_hready / req_ready high at cycle 3. Each wait state adds one cycle.
- Store lane replication on hwdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: unchanged
- Load extraction, with lane = addr[1:0]:
  - byte: hrdata[8*lane +: 8], extended to 32 bits.
  - half: hrdata[16*lane[1] +: 16], extended to 32 bits.
  - word: hrdata unchanged.
  - Extension is sign unless req_unsigned is set.
- load_data holds its value until the next successful load.
- Pulse outputs (rf_hready, misalign_err, bus_err) are exactly one cycle and mutually exclusive.
- A request presented outside IDLE is ignored (req_ready=0); the requester must hold it.
- HTRANS never issues SEQ or BUSY.

Test Plan:
- Load word, addr 0x100, hrdata 0xDEADBEEF, no wait states -> htrans=10 in cycle 1, rf_hready in cycle 3, load_data=0xDEADBEEF.
- Load byte signed, addr 0x103, hrdata 0x80FF_0000 -> load_data=0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
- Store half, addr 0x22, wdata 0x1234ABCD, hready low for 3 cycles in the data phase -> hsize=001, hwdata=0xABCDABCD held stable, transfer_on high 5 cycles, no rf_hready.
- Load word, addr 0x102 -> misalign_err one cycle, htrans stays 00, state IDLE.
- Slave ERROR (cycle 1: hready=0, hresp=1; cycle 2: hready=1, hresp=1) -> bus_err one-cycle pulse, load_data unchanged, req_ready returns to 1.
- rst asserted during an address-phase wait -> next cycle htrans=00, transfer_on=0, no pulses.

Source files
------------

// File: rtl/ahb_lsu_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lsu_master
//  Description : Load/store bus master. Runs one AHB-Lite single transfer per
//                request, replicates store data across byte lanes, and
//                extracts plus sign/zero-extends load data for register
//                write-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lsu_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              req_ready,
    output logic              transfer_on,
    output logic              rf_hready,
    output logic [DATA_W-1:0] load_data,
    output logic              misalign_err,
    output logic              bus_err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                write_q, write_d;
    logic                unsigned_q, unsigned_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                rf_hready_q, rf_hready_d;
    logic                misalign_q, misalign_d;
    logic                bus_err_q, bus_err_d;

    logic                w_misalign;
    logic [DATA_W-1:0]   w_wdata_rep;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic                w_sign;
    logic [DATA_W-1:0]   w_load_ext;

    // Alignment check and store-lane replication of the incoming request
    always_comb begin
        w_misalign  = 1'b0;
        w_wdata_rep = wdata_in;
        case (req_size)
            SZ_BYTE: w_wdata_rep = {(DATA_W/8){wdata_in[7:0]}};
            SZ_HALF: begin
                w_wdata_rep = {(DATA_W/16){wdata_in[15:0]}};
                w_misalign  = addr_in[0];
            end
            SZ_WORD: w_misalign = (addr_in[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    // Lane extraction and sign/zero extension of the read data
    always_comb begin
        case (addr_q[1:0])
            2'd0:    w_byte = hrdata[7:0];
            2'd1:    w_byte = hrdata[15:8];
            2'd2:    w_byte = hrdata[23:16];
            default: w_byte = hrdata[31:24];
        endcase
        w_half = addr_q[1] ? hrdata[31:16] : hrdata[15:0];
        w_sign = 1'b0;
        case (size_q)
            SZ_BYTE: begin
                w_sign     = ~unsigned_q & w_byte[7];
                w_load_ext = {{(DATA_W-8){w_sign}}, w_byte};
            end
            SZ_HALF: begin
                w_sign     = ~unsigned_q & w_half[15];
                w_load_ext = {{(DATA_W-16){w_sign}}, w_half};
            end
            default: w_load_ext = hrdata;
        endcase
    end

    // Next-state and datapath update for the transfer FSM
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        write_d     = write_q;
        unsigned_d  = unsigned_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        rf_hready_d = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_misalign) begin
                        misalign_d = 1'b1;
                    end else begin
                        addr_d     = addr_in;
                        size_d     = req_size;
                        write_d    = req_write;
                        unsigned_d = req_unsigned;
                        wdata_d    = w_wdata_rep;
                        state_d    = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (hready) state_d = S_DATA;
            end
            S_DATA: begin
                if (hresp) begin
                    // An ERROR completing in a single cycle is still an error.
                    if (hready) begin
                        bus_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_ERR2;
                    end
                end else if (hready) begin
                    if (!write_q) begin
                        load_data_d = w_load_ext;
                        rf_hready_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_ERR2: begin
                if (hready) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= 2'b00;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            wdata_q     <= '0;
            load_data_q <= '0;
            rf_hready_q <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            write_q     <= write_d;
            unsigned_q  <= unsigned_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            rf_hready_q <= rf_hready_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign transfer_on  = (state_q != S_IDLE);
    assign htrans       = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign haddr        = addr_q;
    assign hwrite       = write_q;
    assign hsize        = {1'b0, size_q};
    assign hwdata       = wdata_q;
    assign load_data    = load_data_q;
    assign rf_hready    = rf_hready_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lsu_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_lsu_master
//  Description : Directed self-checking bench for ahb_lsu_master.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lsu_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] addr_in, wdata_in;
    logic        req_ready, transfer_on, rf_hready, misalign_err, bus_err;
    logic [31:0] load_data, haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hready, hresp;
    logic [2:0]  hsize;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_lsu_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .addr_in(addr_in), .wdata_in(wdata_in),
        .req_ready(req_ready), .transfer_on(transfer_on), .rf_hready(rf_hready),
        .load_data(load_data), .misalign_err(misalign_err), .bus_err(bus_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [1:0] sz,
                         input logic wr, input logic uns, input logic [31:0] wd);
        req_valid    = 1'b1;
        addr_in      = a;
        req_size     = sz;
        req_write    = wr;
        req_unsigned = uns;
        wdata_in     = wd;
    endtask

    // Zero-wait load: returns positioned in cycle 3 (rf_hready expected high).
    task automatic run_load(input logic [31:0] a, input logic [1:0] sz,
                            input logic uns, input logic [31:0] rd);
        issue(a, sz, 1'b0, uns, 32'h0);
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = rd;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_checks++; if (htrans !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %b expected 00", htrans); end
        n_checks++; if ({haddr, hwdata, load_data} !== 96'h0) begin n_fail++; $display("FAIL rst_regs: got %h %h %h expected 0", haddr, hwdata, load_data); end
        n_checks++; if ({hsize, hwrite} !== 4'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b %b expected 0", hsize, hwrite); end
        n_checks++; if ({transfer_on, rf_hready, misalign_err, bus_err} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", {transfer_on, rf_hready, misalign_err, bus_err}); end
        rst = 1'b0;
        tick;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_load_word;
        issue(32'h100, 2'b10, 1'b0, 1'b0, 32'h0);
        hready = 1'b1; hresp = 1'b0; hrdata = 32'hDEADBEEF;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL lw_ready0: got %b expected 1", req_ready); end
        tick;
        req_valid = 1'b0;
        n_checks++; if (htrans !== 2'b10) begin n_fail++; $display("FAIL lw_htrans1: got %b expected 10", htrans); end
        n_checks++; if ({haddr, hsize, hwrite} !== {32'h100, 3'b010, 1'b0}) begin n_fail++; $display("FAIL lw_addrphase: got %h %b %b expected 100 010 0", haddr, hsize, hwrite); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL lw_ready1: got %b expected 0", req_ready); end
        tick;
        n_checks++; if ({htrans, rf_hready, transfer_on} !== 4'b0001) begin n_fail++; $display("FAIL lw_dataphase: got %b expected 0001", {htrans, rf_hready, transfer_on}); end
        tick;
        n_checks++; if ({rf_hready, req_ready, transfer_on} !== 3'b110) begin n_fail++; $display("FAIL lw_done: got %b expected 110", {rf_hready, req_ready, transfer_on}); end
        n_checks++; if (load_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", load_data); end
        tick;
        n_checks++; if (rf_hready !== 1'b0) begin n_fail++; $display("FAIL lw_pulse: got %b expected 0", rf_hready); end
    endtask

    task automatic test_load_extend;
        run_load(32'h103, 2'b00, 1'b0, 32'h80FF0000);
        n_checks++; if (load_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed: got %h expected ffffff80", load_data); end
        run_load(32'h103, 2'b00, 1'b1, 32'h80FF0000);
        n_checks++; if (load_data !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h expected 00000080", load_data); end
        run_load(32'h102, 2'b00, 1'b0, 32'h80FF0000);
        n_checks++; if (load_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL lb_lane2: got %h expected ffffffff", load_data); end
        run_load(32'h101, 2'b00, 1'b1, 32'h80FF5A00);
        n_checks++; if (load_data !== 32'h0000005A) begin n_fail++; $display("FAIL lbu_lane1: got %h expected 0000005a", load_data); end
        run_load(32'h102, 2'b01, 1'b0, 32'h80FF1234);
        n_checks++; if (load_data !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_hi: got %h expected ffff80ff", load_data); end
        run_load(32'h100, 2'b01, 1'b1, 32'h80FF9234);
        n_checks++; if (load_data !== 32'h00009234) begin n_fail++; $display("FAIL lhu_lo: got %h expected 00009234", load_data); end
        tick;
    endtask

    task automatic test_store_wait;
        int on_cnt = 0;
        int rf_cnt = 0;
        issue(32'h22, 2'b01, 1'b1, 1'b0, 32'h1234ABCD);
        hready = 1'b1; hresp = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick;
            req_valid = 1'b0;
            if (transfer_on === 1'b1) on_cnt++;
            if (rf_hready === 1'b1) rf_cnt++;
            hready = !(c >= 2 && c <= 4);
            if (c == 4) begin
                n_checks++; if ({hsize, hwrite, haddr} !== {3'b001, 1'b1, 32'h22}) begin n_fail++; $display("FAIL sh_ctrl: got %b %b %h expected 001 1 22", hsize, hwrite, haddr); end
                n_checks++; if (hwdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_hwdata: got %h expected abcdabcd", hwdata); end
                n_checks++; if (htrans !== 2'b00) begin n_fail++; $display("FAIL sh_htrans_wait: got %b expected 00", htrans); end
            end
        end
        n_checks++; if (on_cnt != 5) begin n_fail++; $display("FAIL sh_on_cycles: got %0d expected 5", on_cnt); end
        n_checks++; if (rf_cnt != 0) begin n_fail++; $display("FAIL sh_no_rf: got %0d expected 0", rf_cnt); end
        issue(32'h30, 2'b00, 1'b1, 1'b0, 32'h000000A5);
        tick;
        req_valid = 1'b0;
        n_checks++; if (hwdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_hwdata: got %h expected a5a5a5a5", hwdata); end
        tick;
        tick;
        tick;
    endtask

    task automatic test_misalign;
        logic [31:0] prev;
        prev = load_data;
        issue(32'h102, 2'b10, 1'b0, 1'b0, 32'h0);
        tick;
        req_valid = 1'b0;
        n_checks++; if ({misalign_err, htrans, transfer_on, req_ready} !== 5'b10001) begin n_fail++; $display("FAIL mis_word: got %b expected 10001", {misalign_err, htrans, transfer_on, req_ready}); end
        tick;
        n_checks++; if ({misalign_err, transfer_on} !== 2'b00) begin n_fail++; $display("FAIL mis_pulse: got %b expected 00", {misalign_err, transfer_on}); end
        issue(32'h104, 2'b11, 1'b0, 1'b0, 32'h0);
        tick;
        req_valid = 1'b0;
        n_checks++; if ({misalign_err, transfer_on} !== 2'b10) begin n_fail++; $display("FAIL mis_size11: got %b expected 10", {misalign_err, transfer_on}); end
        issue(32'h105, 2'b01, 1'b0, 1'b0, 32'h0);
        tick;
        req_valid = 1'b0;
        n_checks++; if ({misalign_err, transfer_on} !== 2'b10) begin n_fail++; $display("FAIL mis_half: got %b expected 10", {misalign_err, transfer_on}); end
        n_checks++; if (load_data !== prev) begin n_fail++; $display("FAIL mis_ld_hold: got %h expected %h", load_data, prev); end
        tick;
    endtask

    task automatic test_bus_error;
        logic [31:0] prev;
        prev = load_data;
        issue(32'h200, 2'b10, 1'b0, 1'b0, 32'h0);
        hready = 1'b1; hresp = 1'b0; hrdata = 32'h0BADF00D;
        tick;
        req_valid = 1'b0;
        tick;
        hready = 1'b0; hresp = 1'b1;
        tick;
        hready = 1'b1; hresp = 1'b1;
        n_checks++; if ({bus_err, transfer_on} !== 2'b01) begin n_fail++; $display("FAIL err_wait: got %b expected 01", {bus_err, transfer_on}); end
        tick;
        hresp = 1'b0;
        n_checks++; if ({bus_err, rf_hready, req_ready} !== 3'b101) begin n_fail++; $display("FAIL err_pulse: got %b expected 101", {bus_err, rf_hready, req_ready}); end
        n_checks++; if (load_data !== prev) begin n_fail++; $display("FAIL err_ld_hold: got %h expected %h", load_data, prev); end
        tick;
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b expected 0", bus_err); end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        issue(32'h300, 2'b10, 1'b0, 1'b0, 32'h0);
        hready = 1'b0; hresp = 1'b0;
        tick;
        req_valid = 1'b0;
        tick;
        n_checks++; if (htrans !== 2'b10) begin n_fail++; $display("FAIL rm_addr_wait: got %b expected 10", htrans); end
        rst = 1'b1;
        hready = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if ({htrans, transfer_on} !== 3'b000) begin n_fail++; $display("FAIL rm_idle: got %b expected 000", {htrans, transfer_on}); end
        for (int c = 0; c < 3; c++) begin
            if (rf_hready || bus_err || misalign_err) pulses++;
            tick;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rm_no_pulse: got %0d expected 0", pulses); end
    endtask

    task automatic test_back_to_back;
        issue(32'h100, 2'b10, 1'b0, 1'b0, 32'h0);
        hready = 1'b1; hresp = 1'b0; hrdata = 32'h11223344;
        tick;
        issue(32'h106, 2'b01, 1'b0, 1'b1, 32'h0);
        tick;
        n_checks++; if (haddr !== 32'h100) begin n_fail++; $display("FAIL b2b_ignored: got %h expected 100", haddr); end
        tick;
        hrdata = 32'hBEEF1234;
        n_checks++; if ({rf_hready, load_data} !== {1'b1, 32'h11223344}) begin n_fail++; $display("FAIL b2b_first: got %b %h expected 1 11223344", rf_hready, load_data); end
        tick;
        req_valid = 1'b0;
        n_checks++; if ({rf_hready, htrans, haddr} !== {1'b0, 2'b10, 32'h106}) begin n_fail++; $display("FAIL b2b_second_addr: got %b %b %h expected 0 10 106", rf_hready, htrans, haddr); end
        tick;
        tick;
        n_checks++; if ({rf_hready, load_data} !== {1'b1, 32'h0000BEEF}) begin n_fail++; $display("FAIL b2b_second: got %b %h expected 1 0000beef", rf_hready, load_data); end
        tick;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; addr_in = 32'h0; wdata_in = 32'h0;
        hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
        test_reset;
        test_load_word;
        test_load_extend;
        test_store_wait;
        test_misalign;
        test_bus_error;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
